// File: rtl/dino_motion_ctrl_pkg.sv
// Shared constants, state encoding and arithmetic helper for the dino motion block.
// No timing of its own: constants and a pure function.
// No flow control: compile-time values only.
package dino_motion_ctrl_pkg;

    localparam int GROUND  = 335;  // y of the ground line
    localparam int DINO_H  = 60;   // sprite height in pixels
    localparam int DINO_X  = 50;   // fixed horizontal sprite origin
    localparam int JUMP_V  = 12;   // launch velocity, px/frame upward
    localparam int GRAVITY = 1;    // normal velocity decrement per frame
    localparam int FAST_G  = 3;    // decrement while down is held in the air
    localparam int MIN_Y   = 0;    // ceiling clamp

    // Resting y of the sprite origin, plus signed copies for the 11-bit compares
    localparam logic [9:0]         Y_TOP    = 10'(GROUND - DINO_H);
    localparam logic [9:0]         Y_LAUNCH = 10'(GROUND - DINO_H - JUMP_V);
    localparam logic signed [10:0] Y_TOP_S  = 11'(GROUND - DINO_H);
    localparam logic signed [10:0] Y_MIN_S  = 11'(MIN_Y);
    localparam logic signed [7:0]  V_LAUNCH = 8'(JUMP_V - GRAVITY);
    localparam logic signed [7:0]  G_NORM   = 8'(GRAVITY);
    localparam logic signed [7:0]  G_FAST   = 8'(FAST_G);

    // Encoding is shared with the VGA controller and score logic
    typedef enum logic [2:0] {
        ST_GROUND = 3'd0,
        ST_DUCK   = 3'd1,
        ST_RISE   = 3'd2,
        ST_FALL   = 3'd3,
        ST_FROZEN = 3'd4
    } state_e;

    // Next y for an upward-positive velocity, widened so under/overflow is visible
    function automatic logic signed [10:0] y_minus_vel(input logic [9:0] y,
                                                       input logic signed [7:0] v);
        return $signed({1'b0, y}) - $signed({{3{v[7]}}, v});
    endfunction

endpackage

// File: rtl/dino_motion_ctrl_sync_edge.sv
// 2-flop synchronizer followed by a registered rising-edge detector.
// Latency: edge_o pulses 3 clk edges after d_i rises, for exactly one clk.
// No flow control: a held-high input yields a single pulse.
module sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic sync_dly_q;
    logic edge_q;

    // Synchronize the asynchronous input and register its rising edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            sync_dly_q <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            meta_q     <= d_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
            edge_q     <= sync_q & ~sync_dly_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Frame-locked jump/duck physics producing the dino sprite origin for the VGA controller.
// Latency: position updates 1 clk after the registered frame-tick edge; stable between frames.
// No flow control: one update per frame tick, game_over freezes everything until reset.
module dino_motion_ctrl
    import dino_motion_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        up,
    input  logic        down,
    input  logic        frame_tick,
    input  logic        game_over,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic        jumping,
    output logic        ducking
);

    logic up_edge;
    logic tick_edge;
    logic down_meta_q, down_sync_q;

    state_e             state_q, state_d;
    logic [9:0]         y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic               jump_req_q, jump_req_d;
    logic               jumping_q, jumping_d;
    logic               ducking_q, ducking_d;

    logic signed [7:0]  g;
    logic signed [7:0]  vel_dec;
    logic signed [10:0] next_y;

    sync_edge u_up_sync (
        .clk_i  (clk),
        .rst_i  (reset),
        .d_i    (up),
        .edge_o (up_edge)
    );

    sync_edge u_tick_sync (
        .clk_i  (clk),
        .rst_i  (reset),
        .d_i    (frame_tick),
        .edge_o (tick_edge)
    );

    // Down is a level input, so only the synchronized level is needed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            down_meta_q <= 1'b0;
            down_sync_q <= 1'b0;
        end else begin
            down_meta_q <= down;
            down_sync_q <= down_meta_q;
        end
    end

    // Motion state register; reset puts the dino straight back on the ground
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_GROUND;
            y_q        <= Y_TOP;
            vel_q      <= '0;
            jump_req_q <= 1'b0;
            jumping_q  <= 1'b0;
            ducking_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            vel_q      <= vel_d;
            jump_req_q <= jump_req_d;
            jumping_q  <= jumping_d;
            ducking_q  <= ducking_d;
        end
    end

    // Per-frame physics step; game_over overrides any tick arriving in the same clk
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        vel_d      = vel_q;
        jump_req_d = jump_req_q;
        jumping_d  = jumping_q;
        ducking_d  = ducking_q;
        g          = down_sync_q ? G_FAST : G_NORM;
        vel_dec    = vel_q - g;
        next_y     = y_minus_vel(y_q, vel_q);

        if (game_over || state_q == ST_FROZEN) begin
            state_d = ST_FROZEN;
        end else begin
            if (tick_edge) begin
                // The tick consumes any pending request whatever the state
                jump_req_d = 1'b0;
                case (state_q)
                    ST_GROUND, ST_DUCK: begin
                        if (jump_req_q) begin
                            state_d = ST_RISE;
                            vel_d   = V_LAUNCH;
                            y_d     = Y_LAUNCH;
                        end else if (state_q == ST_GROUND && down_sync_q) begin
                            state_d = ST_DUCK;
                        end else if (state_q == ST_DUCK && !down_sync_q) begin
                            state_d = ST_GROUND;
                        end
                    end
                    ST_RISE: begin
                        y_d   = (next_y < Y_MIN_S) ? Y_MIN_S[9:0] : next_y[9:0];
                        vel_d = vel_dec;
                        if (vel_dec <= 8'sd0) begin
                            state_d = ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        if (next_y >= Y_TOP_S) begin
                            state_d = ST_GROUND;
                            y_d     = Y_TOP;
                            vel_d   = '0;
                        end else begin
                            y_d   = next_y[9:0];
                            vel_d = vel_dec;
                        end
                    end
                    default: begin
                        state_d = ST_FROZEN;
                    end
                endcase
            end
            // A new press only arms the next frame if we end this cycle on the ground
            if (up_edge && (state_d == ST_GROUND || state_d == ST_DUCK)) begin
                jump_req_d = 1'b1;
            end
            jumping_d = (state_d == ST_RISE) || (state_d == ST_FALL);
            ducking_d = (state_d == ST_DUCK);
        end
    end

    assign dino_x  = 32'(DINO_X);
    assign dino_y  = {22'd0, y_q};
    assign jumping = jumping_q;
    assign ducking = ducking_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
module tb_dino_motion_ctrl;

    logic        clk = 1'b0;
    logic        reset, up, down, frame_tick, game_over;
    logic [31:0] dino_x, dino_y;
    logic        jumping, ducking;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integer kinematics, one call per frame
    int m_y, m_v;
    bit m_air, m_rising, m_duck, m_req, m_frozen;

    int min_y, max_y, land_t;

    always #5 clk = ~clk;

    dino_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .up         (up),
        .down       (down),
        .frame_tick (frame_tick),
        .game_over  (game_over),
        .dino_x     (dino_x),
        .dino_y     (dino_y),
        .jumping    (jumping),
        .ducking    (ducking)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_y"}, dino_y, 32'(m_y));
        chk({tag, "_jumping"}, {31'd0, jumping}, {31'd0, m_air});
        chk({tag, "_ducking"}, {31'd0, ducking}, {31'd0, m_duck});
        chk({tag, "_x"}, dino_x, 32'd50);
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_y = 275; m_v = 0;
        m_air = 0; m_rising = 0; m_duck = 0; m_req = 0; m_frozen = 0;
    endtask

    task automatic model_tick();
        int ny, grav;
        if (m_frozen) return;
        grav = down ? 3 : 1;
        if (!m_air) begin
            if (m_req) begin
                m_air = 1; m_rising = 1; m_duck = 0;
                m_y = 275 - 12; m_v = 12 - 1;
            end else begin
                m_duck = down;
            end
        end else begin
            ny = m_y - m_v;
            if (m_rising) begin
                m_y = (ny < 0) ? 0 : ny;
                m_v = m_v - grav;
                if (m_v <= 0) m_rising = 0;
            end else if (ny >= 275) begin
                m_air = 0; m_y = 275; m_v = 0;
            end else begin
                m_y = ny;
                m_v = m_v - grav;
            end
        end
        m_req = 0;
    endtask

    task automatic apply_reset();
        reset = 1; up = 0; down = 0; frame_tick = 0; game_over = 0;
        clks(3);
        reset = 0;
        clks(2);
        model_reset();
    endtask

    task automatic tick(input int w, input string tag);
        frame_tick = 1;
        clks(w);
        frame_tick = 0;
        clks(6);
        model_tick();
        check_state(tag);
    endtask

    task automatic press_up();
        up = 1;
        clks(2);
        up = 0;
        clks(5);
        if (!m_frozen && !m_air) m_req = 1;
    endtask

    task automatic set_down(input logic v);
        down = v;
        clks(4);
    endtask

    initial begin
        // Idle after reset: dino stays on the ground
        apply_reset();
        check_state("reset");
        for (int i = 0; i < 100; i++) tick($urandom_range(1, 4), "idle");

        // Plain jump: launch, early trajectory, apex and landing
        press_up();
        tick(1, "launch");
        chk("launch_y", dino_y, 32'd263);
        min_y = 263;
        for (int i = 2; i <= 26; i++) begin
            tick($urandom_range(1, 4), "jump");
            if (i == 2) chk("jump_t2", dino_y, 32'd252);
            if (i == 3) chk("jump_t3", dino_y, 32'd242);
            if (int'(dino_y) < min_y) min_y = int'(dino_y);
        end
        chk("apex", 32'(min_y), 32'd197);
        chk("landed_y", dino_y, 32'd275);
        chk("landed_jumping", {31'd0, jumping}, 32'd0);

        // Second press at the apex is ignored
        press_up();
        for (int i = 1; i <= 26; i++) begin
            tick(1, "dbl");
            if (i == 12) begin
                chk("dbl_apex", dino_y, 32'd197);
                press_up();
            end
        end
        chk("dbl_landed_y", dino_y, 32'd275);
        chk("dbl_landed_jumping", {31'd0, jumping}, 32'd0);

        // Duck on the ground, then fast fall while down is held in the air
        set_down(1);
        tick(1, "duck");
        chk("duck_on", {31'd0, ducking}, 32'd1);
        set_down(0);
        tick(1, "unduck");
        chk("duck_off", {31'd0, ducking}, 32'd0);
        press_up();
        tick(1, "fast_launch");
        set_down(1);
        land_t = 99; max_y = 0;
        for (int i = 2; i <= 26; i++) begin
            tick(1, "fast");
            if (int'(dino_y) > max_y) max_y = int'(dino_y);
            if (!jumping && land_t == 99) land_t = i;
        end
        chk("fast_land_early", {31'd0, land_t < 26}, 32'd1);
        chk("fast_never_below", {31'd0, max_y <= 275}, 32'd1);
        set_down(0);

        // game_over mid-jump freezes everything, reset recovers
        apply_reset();
        press_up();
        for (int i = 0; i < 5; i++) tick(1, "pre_freeze");
        game_over = 1;
        clks(2);
        m_frozen = 1;
        check_state("frozen");
        chk("frozen_y", dino_y, 32'd225);
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 3) press_up();
            tick($urandom_range(1, 3), "frozen_hold");
        end
        apply_reset();
        check_state("unfreeze");
        chk("unfreeze_y", dino_y, 32'd275);

        // Long frame_tick pulse gives exactly one update
        press_up();
        tick(4, "wide_tick");
        chk("wide_tick_y", dino_y, 32'd263);
        clks(20);
        chk("wide_tick_hold", dino_y, 32'd263);
        tick(1, "after_wide");

        // game_over arriving with a tick blocks the motion update
        game_over = 1;
        frame_tick = 1;
        clks(1);
        frame_tick = 0;
        clks(6);
        m_frozen = 1;
        check_state("go_tick");
        chk("go_tick_y", dino_y, 32'd252);

        // Random button activity against the model
        apply_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) press_up();
            set_down(logic'($urandom_range(0, 4) == 0));
            tick($urandom_range(1, 4), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
